axi_stream_link: RTL and testbench

Decimating AXI-Stream capture link between the ring buffer and the trigger FFT. After a frame request, a stream master forwards every fourth input sample over an internal valid/ready stream. A stream slave writes each accepted word into a 32x64 simple dual-port RAM. The FFT loader reads the RAM on a separate read port.

---
 rtl/axi_stream_link_pkg.sv | 29 ++
 rtl/link_dp_ram.sv | 36 +++
 rtl/axi_stream_link.sv | 136 +++++++++++++
 tb/tb_axi_stream_link.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_link_pkg.sv
// Shared constants, master state encoding and address bit-reversal helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_stream_link_pkg;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = $clog2(DEPTH);

  // Sample count reaches DEPTH once the last word of a frame is latched.
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } mstate_t;

  // Mirror the address bits so a linear index lands on FFT input order.
  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      r[b] = a[ADDR_W-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/link_dp_ram.sv
// Simple dual-port RAM: synchronous write on port A, registered read on port B.
// Latency: 1 cycle from rd_en/rd_addr sampling edge; same-address collision is read-first.
// Backpressure: none; rd_data holds its last value while rd_en is low.
module link_dp_ram #(
  parameter int W  = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [2**AW];

  // Port A write; storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Port B registered read; nonblocking update makes collisions return the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/axi_stream_link.sv
// Decimating capture link: forwards every fourth sample of a requested frame into a RAM.
// Latency: sample rise registered at edge N -> t_valid after N+1 -> RAM write on handshake edge.
// Backpressure: one-word holding stage; a new sample arriving while a word is pending is dropped
// and flagged in sticky overflow. Build option BIT_REVERSE_EN bit-reverses the read address.
module axi_stream_link
  import axi_stream_link_pkg::*;
(
  input  logic              clk,
  input  logic              reset_b,
  input  logic [DATA_W-1:0] in_data,
  input  logic              fourth_sample,
  input  logic              send_frame,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              t_valid,
  output logic [DATA_W-1:0] t_data,
  output logic              t_ready,
  output logic              frame_active,
  output logic              frame_done,
  output logic              overflow
);

  logic              send_q;
  logic              send_prev;
  logic              fs_q;
  logic              fs_prev;
  logic              send_rise;
  logic              fs_rise;
  logic              hs;
  mstate_t           state;
  logic [ADDR_W:0]   sample_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic              wrap_q;
  logic [ADDR_W-1:0] ram_rd_addr;

  // Register the strobes once, then keep a delayed copy for rise detection.
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      send_q    <= 1'b0;
      send_prev <= 1'b0;
      fs_q      <= 1'b0;
      fs_prev   <= 1'b0;
    end else begin
      send_q    <= send_frame;
      send_prev <= send_q;
      fs_q      <= fourth_sample;
      fs_prev   <= fs_q;
    end
  end

  assign send_rise = send_q & ~send_prev;
  assign fs_rise   = fs_q & ~fs_prev;
  assign hs        = t_valid & t_ready;

  // Master: collect DEPTH decimated samples per request into a one-word stream stage.
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      state      <= ST_IDLE;
      sample_cnt <= '0;
      t_valid    <= 1'b0;
      t_data     <= '0;
      overflow   <= 1'b0;
    end else begin
      if (hs) begin
        t_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (send_rise) begin
            state      <= ST_COLLECT;
            sample_cnt <= '0;
          end
        end
        ST_COLLECT: begin
          // A request while collecting is ignored: the frame runs to completion.
          if (fs_rise) begin
            if (t_valid) begin
              overflow <= 1'b1;
            end else begin
              t_data     <= in_data;
              t_valid    <= 1'b1;
              sample_cnt <= sample_cnt + (ADDR_W + 1)'(1);
            end
          end
          if (hs && (sample_cnt == CNT_FULL)) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign frame_active = (state == ST_COLLECT);

  // Slave: always ready, advance write pointer per accepted word, flag the wrap.
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      t_ready    <= 1'b0;
      wr_addr    <= '0;
      wrap_q     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      t_ready    <= 1'b1;
      wrap_q     <= hs && (wr_addr == ADDR_MAX);
      frame_done <= wrap_q;
      if (hs) begin
        wr_addr <= wr_addr + ADDR_W'(1);
      end
    end
  end

`ifdef BIT_REVERSE_EN
  assign ram_rd_addr = bitrev(rd_addr);
`else
  assign ram_rd_addr = rd_addr;
`endif

  link_dp_ram #(
    .W  (DATA_W),
    .AW (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (reset_b),
    .wr_en   (hs),
    .wr_addr (wr_addr),
    .wr_data (t_data),
    .rd_en   (rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_axi_stream_link.sv
// Randomized bench for axi_stream_link against a frame-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_axi_stream_link;

  localparam int DW = 32;
  localparam int N  = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          fourth_sample;
  logic          send_frame;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          t_valid;
  logic [DW-1:0] t_data;
  logic          t_ready;
  logic          frame_active;
  logic          frame_done;
  logic          overflow;

  always #5 clk = ~clk;

  axi_stream_link dut (
    .clk           (clk),
    .reset_b       (rst),
    .in_data       (in_data),
    .fourth_sample (fourth_sample),
    .send_frame    (send_frame),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .t_valid       (t_valid),
    .t_data        (t_data),
    .t_ready       (t_ready),
    .frame_active  (frame_active),
    .frame_done    (frame_done),
    .overflow      (overflow)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Observed stream words and done pulses.
  logic [DW-1:0] hs_q[$];
  int            done_seen = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (t_valid && t_ready) hs_q.push_back(t_data);
      if (frame_done) done_seen++;
    end
  end

  // Frame-level reference model.
  logic [DW-1:0] m_ram[N];
  logic [DW-1:0] exp_q[$];
  int            m_ptr     = 0;
  int            m_cnt     = 0;
  bit            m_collect = 0;
  int            m_done    = 0;

  task automatic model_req();
    if (!m_collect) begin
      m_collect = 1;
      m_cnt     = 0;
    end
  endtask

  task automatic model_sample(input logic [DW-1:0] d);
    if (m_collect) begin
      exp_q.push_back(d);
      m_ram[m_ptr] = d;
      m_ptr = (m_ptr + 1) % N;
      m_cnt++;
      if (m_cnt == N) begin
        m_collect = 0;
        m_done++;
      end
    end
  endtask

  task automatic model_reset();
    m_ptr     = 0;
    m_cnt     = 0;
    m_collect = 0;
  endtask

  function automatic int rev6(input int k);
    int r = 0;
    for (int b = 0; b < AW; b++) if (((k >> b) & 1) != 0) r |= 1 << (AW - 1 - b);
    return r;
  endfunction

  task automatic pulse(input logic [DW-1:0] d, input int hi, input int lo);
    @(negedge clk);
    in_data       = d;
    fourth_sample = 1'b1;
    repeat (hi) @(negedge clk);
    fourth_sample = 1'b0;
    repeat (lo) @(negedge clk);
    model_sample(d);
  endtask

  task automatic req_frame();
    @(negedge clk);
    send_frame = 1'b1;
    repeat (3) @(negedge clk);
    send_frame = 1'b0;
    repeat (2) @(negedge clk);
    model_req();
  endtask

  task automatic run_frame(input int n, input bit fixed, input int mid_req);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      if (i == mid_req) req_frame();
      d = fixed ? DW'(32'h1000 + i) : $urandom;
      if (fixed) pulse(d, 14, 182);
      else       pulse(d, $urandom_range(2, 14), $urandom_range(4, 20));
    end
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, DW'(hs_q.size()), DW'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++)
      check($sformatf("%s_word%0d", tag, i), hs_q[i], exp_q[i]);
    hs_q.delete();
    exp_q.delete();
  endtask

  task automatic readback(input string tag);
    int            a;
    logic [DW-1:0] last;
    last = '0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      rd_en   = 1'b1;
      rd_addr = AW'(k);
`ifdef BIT_REVERSE_EN
      a = rev6(k);
`else
      a = k;
`endif
      @(negedge clk);
      check($sformatf("%s_rd%0d", tag, k), rd_data, m_ram[a]);
      last = m_ram[a];
    end
    rd_en   = 1'b0;
    rd_addr = AW'($urandom);
    repeat (2) @(negedge clk);
    check({tag, "_rd_hold"}, rd_data, last);
  endtask

  int done0;
  int hs0;

  initial begin
    rst           = 1'b1;
    in_data       = '0;
    fourth_sample = 1'b0;
    send_frame    = 1'b0;
    rd_en         = 1'b0;
    rd_addr       = '0;
    repeat (3) @(negedge clk);
    check("rst_t_valid", DW'(t_valid), 0);
    check("rst_t_data", t_data, 0);
    check("rst_t_ready", DW'(t_ready), 0);
    check("rst_frame_active", DW'(frame_active), 0);
    check("rst_frame_done", DW'(frame_done), 0);
    check("rst_overflow", DW'(overflow), 0);
    check("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("t_ready_up", DW'(t_ready), 1);

    // Pulses with no frame request must produce nothing.
    for (int i = 0; i < 3; i++) pulse($urandom, $urandom_range(2, 14), $urandom_range(4, 20));
    check_stream("noreq");
    check("noreq_active", DW'(frame_active), 0);

    // Fixed-pattern frame with an ignored mid-frame request at pulse 10.
    done0 = done_seen;
    req_frame();
    check("f1_active", DW'(frame_active), 1);
    run_frame(N, 1'b1, 10);
    check_stream("f1");
    check("f1_done", DW'(done_seen - done0), DW'(m_done));
    check("f1_active_end", DW'(frame_active), 0);
    check("f1_overflow", DW'(overflow), 0);
    readback("f1");
    @(negedge clk);
    rd_en   = 1'b1;
    rd_addr = AW'(21);
    @(negedge clk);
    rd_en = 1'b0;
`ifdef BIT_REVERSE_EN
    check("f1_addr21", rd_data, 32'h1000 + 42);
`else
    check("f1_addr21", rd_data, 32'h1000 + 21);
`endif

    // Level strobe held 14 cycles gives exactly one word, then a random frame overwrites.
    done0 = done_seen;
    req_frame();
    hs0 = hs_q.size();
    pulse(32'hA5A5A5A5, 14, 8);
    check("hold_one_hs", DW'(hs_q.size() - hs0), 1);
    if (hs_q.size() > 0) check("hold_data", hs_q[hs_q.size() - 1], 32'hA5A5A5A5);
    run_frame(N - 1, 1'b0, -1);
    check_stream("f2");
    check("f2_done", DW'(done_seen - done0), DW'(m_done - 1));
    check("f2_active_end", DW'(frame_active), 0);
    readback("f2");

    // Reset mid-frame after 20 words, then a fresh frame from address 0.
    req_frame();
    run_frame(20, 1'b0, -1);
    check_stream("f3_part");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_t_valid", DW'(t_valid), 0);
    check("midrst_active", DW'(frame_active), 0);
    check("midrst_overflow", DW'(overflow), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("postrst_active", DW'(frame_active), 0);
    done0 = done_seen;
    req_frame();
    run_frame(N, 1'b0, -1);
    check_stream("f4");
    check("f4_done", DW'(done_seen - done0), 1);
    check("f4_overflow", DW'(overflow), 0);
    readback("f4");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
